// File: rtl/vid_clk_pkg.sv
// Shared types and default timing constants for the video clock domain
// controllers (PLL reset sequencing and related clock-crossing helpers).
package vid_clk_pkg;

    typedef enum logic [2:0] {
        S_PRST  = 3'd0,
        S_WAIT  = 3'd1,
        S_STAB  = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } pll_state_e;

    localparam int unsigned DEF_PLL_RST_CYC  = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT = 50000;
    localparam int unsigned DEF_STABLE_CYC   = 1024;
    localparam int unsigned DEF_MAX_RETRY    = 7;
    localparam int unsigned RETRY_W          = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for lock with timeout and
// bounded retries, qualifies lock stability, then releases downstream reset.
module pll_rst_seq
    import vid_clk_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC  = DEF_PLL_RST_CYC,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYC   = DEF_STABLE_CYC,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_lock_i,
    output logic               pll_reset_o,
    output logic               pix_rst_o,
    output logic               ready_o,
    output logic               fault_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    localparam int unsigned CNT_W = $clog2(max3(LOCK_TIMEOUT, STABLE_CYC, PLL_RST_CYC) + 1);

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d   (pll_lock_i),
        .q   (lock_s)
    );

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q <= S_PRST;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // The shared counter restarts from zero on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        unique case (state_q)
            S_PRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STAB;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_d == RETRY_MAX) ? S_FAULT : S_PRST;
                end
            end
            S_STAB: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = S_PRST;
                end
            end
            S_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_PRST;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pll_reset_o = (state_q == S_PRST) || (state_q == S_FAULT);
        ready_o     = (state_q == S_RUN);
        pix_rst_o   = (state_q != S_RUN);
        fault_o     = (state_q == S_FAULT);
        retry_cnt_o = retry_q;
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Randomized and scenario-driven bench for pll_rst_seq against a countdown-based
// behavioural model of the reset/lock sequencing rules.
module tb_pll_rst_seq;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_TO   = 20;
    localparam int unsigned P_STAB = 8;
    localparam int unsigned P_MAX  = 3;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       pll_reset_o, pix_rst_o, ready_o, fault_o;
    logic [3:0] retry_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pll_rst_seq #(
        .PLL_RST_CYC  (P_RST),
        .LOCK_TIMEOUT (P_TO),
        .STABLE_CYC   (P_STAB),
        .MAX_RETRY    (P_MAX)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .pll_lock_i  (pll_lock_i),
        .pll_reset_o (pll_reset_o),
        .pix_rst_o   (pix_rst_o),
        .ready_o     (ready_o),
        .fault_o     (fault_o),
        .retry_cnt_o (retry_cnt_o)
    );

    always #5 clkin = ~clkin;

    // Model: phases with countdowns; sync modelled as a 2-entry delay line.
    typedef enum int {M_HOLD, M_WAITING, M_QUAL, M_LIVE, M_DEAD} mphase_e;
    mphase_e     m_phase = M_HOLD;
    int unsigned m_hold_left = P_RST;
    int unsigned m_wait_left = P_TO;
    int unsigned m_good = 0;
    int unsigned m_fails = 0;
    bit          m_dly[2] = '{1'b0, 1'b0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit lk);
        bit seen;
        seen = m_dly[1];
        if (rst) begin
            m_phase = M_HOLD; m_hold_left = P_RST; m_fails = 0; m_dly = '{1'b0, 1'b0};
            return;
        end
        m_dly[1] = m_dly[0];
        m_dly[0] = lk;
        case (m_phase)
            M_HOLD: begin
                m_hold_left--;
                if (m_hold_left == 0) begin m_phase = M_WAITING; m_wait_left = P_TO; end
            end
            M_WAITING: begin
                if (seen) begin
                    m_phase = M_QUAL; m_good = 0;
                end else begin
                    m_wait_left--;
                    if (m_wait_left == 0) begin
                        m_fails++;
                        if (m_fails >= P_MAX) m_phase = M_DEAD;
                        else begin m_phase = M_HOLD; m_hold_left = P_RST; end
                    end
                end
            end
            M_QUAL: begin
                if (!seen) begin
                    m_phase = M_WAITING; m_wait_left = P_TO;
                end else begin
                    m_good++;
                    if (m_good == P_STAB) begin m_phase = M_LIVE; m_fails = 0; end
                end
            end
            M_LIVE: if (!seen) begin m_phase = M_HOLD; m_hold_left = P_RST; end
            default: ;
        endcase
    endtask

    task automatic step(input bit rst, input bit lk);
        @(negedge clkin);
        reset = rst;
        pll_lock_i = lk;
        @(posedge clkin);
        model_step(rst, lk);
        #1;
        check_eq("pll_reset_o", 32'(pll_reset_o), 32'(m_phase == M_HOLD || m_phase == M_DEAD));
        check_eq("ready_o",     32'(ready_o),     32'(m_phase == M_LIVE));
        check_eq("pix_rst_o",   32'(pix_rst_o),   32'(m_phase != M_LIVE));
        check_eq("fault_o",     32'(fault_o),     32'(m_phase == M_DEAD));
        check_eq("retry_cnt_o", 32'(retry_cnt_o), 32'(m_fails));
    endtask

    task automatic run(input int unsigned n, input bit lk);
        for (int unsigned i = 0; i < n; i++) step(1'b0, lk);
    endtask

    task automatic do_reset(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        int unsigned seg;
        bit          lvl;

        // Nominal lock, lock raised 10 cycles after reset release.
        do_reset(3);
        run(10, 1'b0);
        run(40, 1'b1);
        check_eq("nominal_ready", 32'(ready_o), 32'd1);

        // Loss of lock in run, then relock.
        run(30, 1'b0);
        run(30, 1'b1);
        check_eq("relock_ready", 32'(ready_o), 32'd1);

        // Lock never arrives: three attempts then fault.
        do_reset(2);
        run(100, 1'b0);
        check_eq("never_fault", 32'(fault_o), 32'd1);
        check_eq("never_retry", 32'(retry_cnt_o), 32'd3);

        // Reset while in fault, then a glitched lock.
        do_reset(1);
        run(10, 1'b0);
        run(5, 1'b1);
        run(1, 1'b0);
        run(40, 1'b1);
        check_eq("glitch_retry", 32'(retry_cnt_o), 32'd0);

        // Reset during qualification.
        do_reset(1);
        run(2, 1'b0);
        run(10, 1'b1);
        do_reset(1);
        run(40, 1'b1);

        // Sweep lock arrival across all wait-window alignments, incl. the timeout tie.
        for (int unsigned d = 0; d <= 30; d++) begin
            do_reset(1);
            run(d, 1'b0);
            run(20, 1'b1);
        end

        // Random lock segments with occasional resets.
        lvl = 1'b0;
        for (int unsigned k = 0; k < 150; k++) begin
            seg = $urandom_range(1, 40);
            lvl = ~lvl;
            for (int unsigned i = 0; i < seg; i++)
                step(($urandom_range(0, 199) == 0), lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
